// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: control bundle, EX/MEM and MEM/WB
// stage registers, store/load funct3 encodings and the stage FSM states.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic          load_regfile;
    logic          mem_read;
    logic          mem_write;
    store_funct3_t store_type;
    load_funct3_t  load_type;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] alu;
    logic [31:0] rs2_out;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        br;
    logic [31:0] u_imm;
  } stage_regs;

  // Halfword loads may not straddle a word; word loads must be word aligned.
  function automatic logic load_misaligned(load_funct3_t lt, logic [1:0] off);
    case (lt)
      LD_LH, LD_LHU: return (off == 2'd3);
      LD_LW:         return (off != 2'd0);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_store_mask.sv
// Store lane alignment: shifts store data into its byte lane and builds the
// byte-enable mask. Flags stores that cannot be issued as one word access.
module store_mask
  import mem_stage_pkg::*;
(
  input  store_funct3_t store_type_i,
  input  logic [1:0]    off_i,
  input  logic [31:0]   rs2_i,
  output logic [31:0]   wdata_o,
  output logic [3:0]    byte_enable_o,
  output logic          misaligned_o
);

  // Lane shift amount is the byte offset times eight.
  always_comb begin
    wdata_o       = rs2_i;
    byte_enable_o = 4'b1111;
    misaligned_o  = 1'b0;
    case (store_type_i)
      ST_SB: begin
        wdata_o       = {24'b0, rs2_i[7:0]} << {off_i, 3'b000};
        byte_enable_o = 4'b0001 << off_i;
      end
      ST_SH: begin
        wdata_o       = {16'b0, rs2_i[15:0]} << {off_i, 3'b000};
        byte_enable_o = 4'b0011 << off_i;
        misaligned_o  = (off_i == 2'd3);
      end
      ST_SW: begin
        misaligned_o  = (off_i != 2'd0);
      end
      default: begin
        byte_enable_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues dcache reads/writes, stalls while a request is
// outstanding, and owns the MEM/WB register (bundle + raw read word).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  stage_regs        regs_in,
  input  logic             stall_in,
  input  logic             dcache_resp,
  input  logic [width-1:0] dcache_rdata,
  output logic             dcache_read,
  output logic             dcache_write,
  output logic [31:0]      dcache_address,
  output logic [width-1:0] dcache_wdata,
  output logic [3:0]       dcache_byte_enable,
  output logic             stall_out,
  output logic             misaligned,
  output stage_regs        regs_out,
  output logic [width-1:0] dcache_out
);

  mem_state_t       state_q, state_d;
  stage_regs        regs_q, regs_adv;
  logic [width-1:0] dout_q, hold_q;
  logic             mis_q;

  logic [1:0]  off;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        st_mis, ld_mis, mis, mem_op, req_ok, advance, capture;

  assign off    = regs_in.alu[1:0];
  assign mem_op = regs_in.ctrl.mem_read | regs_in.ctrl.mem_write;

  store_mask u_store_mask (
    .store_type_i  (regs_in.ctrl.store_type),
    .off_i         (off),
    .rs2_i         (regs_in.rs2_out),
    .wdata_o       (st_wdata),
    .byte_enable_o (st_be),
    .misaligned_o  (st_mis)
  );

  assign ld_mis = regs_in.ctrl.mem_read & load_misaligned(regs_in.ctrl.load_type, off);
  assign mis    = ld_mis | (regs_in.ctrl.mem_write & st_mis);
  assign req_ok = mem_op & ~mis;

  assign dcache_address     = {regs_in.alu[31:2], 2'b00};
  assign dcache_wdata       = st_wdata;
  assign dcache_byte_enable = regs_in.ctrl.mem_write ? st_be : 4'b1111;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: park in HOLD when the response lands during an external stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_ok & dcache_resp & stall_in) state_d = HOLD;
      HOLD:    if (~stall_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: requests only from IDLE, and dropped while reset is asserted so a
  // pending access is abandoned immediately.
  always_comb begin
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
    stall_out    = 1'b0;
    if (!rst && state_q == IDLE) begin
      dcache_read  = regs_in.ctrl.mem_read & ~mis;
      dcache_write = regs_in.ctrl.mem_write & ~regs_in.ctrl.mem_read & ~mis;
      stall_out    = req_ok & ~dcache_resp;
    end
  end

  assign advance = ~stall_out & ~stall_in;
  assign capture = (state_q == IDLE) & req_ok & dcache_resp & stall_in;

  // A dropped misaligned access must not write the register file.
  always_comb begin
    regs_adv = regs_in;
    regs_adv.ctrl.load_regfile = regs_in.ctrl.load_regfile & ~mis;
  end

  // MEM/WB register, held read word, and the misalignment pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      dout_q <= '0;
      hold_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      if (capture) hold_q <= dcache_rdata;
      if (advance) begin
        regs_q <= regs_adv;
        dout_q <= (state_q == HOLD) ? hold_q : dcache_rdata;
      end
      mis_q <= advance & mis & (state_q == IDLE);
    end
  end

  assign regs_out   = regs_q;
  assign dcache_out = dout_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: store/load hits and misses, HOLD on external
// stall, misaligned drops, reset mid-access and non-memory stall behaviour.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  stage_regs   regs_in;
  logic        stall_in, dcache_resp;
  logic [31:0] dcache_rdata;
  logic        dcache_read, dcache_write, stall_out, misaligned;
  logic [31:0] dcache_address, dcache_wdata, dcache_out;
  logic [3:0]  dcache_byte_enable;
  stage_regs   regs_out;

  int n_cmp = 0;
  int n_fail = 0;

  stage_regs b_sw, b_sb, b_lw, b_lw2;

  mem_stage #(.width(32)) dut (
    .clk(clk), .rst(rst), .regs_in(regs_in), .stall_in(stall_in),
    .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_byte_enable(dcache_byte_enable), .stall_out(stall_out),
    .misaligned(misaligned), .regs_out(regs_out), .dcache_out(dcache_out)
  );

  always #5 clk = ~clk;

  function automatic stage_regs mk(logic lr, logic mr, logic mw, store_funct3_t st,
                                   load_funct3_t lt, logic [31:0] alu, logic [31:0] rs2,
                                   logic [31:0] pc);
    stage_regs r;
    r = '0;
    r.ctrl.load_regfile = lr;
    r.ctrl.mem_read     = mr;
    r.ctrl.mem_write    = mw;
    r.ctrl.store_type   = st;
    r.ctrl.load_type    = lt;
    r.alu     = alu;
    r.rs2_out = rs2;
    r.pc      = pc;
    r.rd      = 5'd7;
    r.u_imm   = 32'h0000_1000;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (regs_out !== '0) begin n_fail++; $display("FAIL rst_regs: got %h want 0", regs_out); end
    n_cmp++; if (dcache_out !== 32'h0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", dcache_out); end
    n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b want 0", misaligned); end
    n_cmp++; if ({dcache_read, dcache_write, stall_out} !== 3'b000) begin n_fail++; $display("FAIL rst_req: got %b want 000", {dcache_read, dcache_write, stall_out}); end
    rst = 1'b0;
  endtask

  task automatic test_sw_hit();
    b_sw = mk(1'b0, 1'b0, 1'b1, ST_SW, LD_LB, 32'h100, 32'hDEADBEEF, 32'h200);
    regs_in = b_sw; dcache_resp = 1'b1; dcache_rdata = 32'hCAFEF00D;
    #1;
    n_cmp++; if ({dcache_read, dcache_write} !== 2'b01) begin n_fail++; $display("FAIL sw_req: got %b want 01", {dcache_read, dcache_write}); end
    n_cmp++; if (dcache_address !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h want 100", dcache_address); end
    n_cmp++; if (dcache_byte_enable !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b want 1111", dcache_byte_enable); end
    n_cmp++; if (dcache_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", dcache_wdata); end
    n_cmp++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got %b want 0", stall_out); end
    step();
    n_cmp++; if (regs_out !== b_sw) begin n_fail++; $display("FAIL sw_regs: got %h want %h", regs_out, b_sw); end
    n_cmp++; if (dcache_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sw_dout: got %h want cafef00d", dcache_out); end
  endtask

  task automatic test_sb_miss();
    b_sb = mk(1'b0, 1'b0, 1'b1, ST_SB, LD_LB, 32'h103, 32'h000000AB, 32'h204);
    regs_in = b_sb; dcache_resp = 1'b0; dcache_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL sb_stall%0d: got %b want 1", i, stall_out); end
      n_cmp++; if (dcache_byte_enable !== 4'b1000) begin n_fail++; $display("FAIL sb_be%0d: got %b want 1000", i, dcache_byte_enable); end
      n_cmp++; if (dcache_wdata !== 32'hAB000000 || dcache_write !== 1'b1) begin n_fail++; $display("FAIL sb_wr%0d: got %h/%b want ab000000/1", i, dcache_wdata, dcache_write); end
      step();
    end
    n_cmp++; if (regs_out !== b_sw) begin n_fail++; $display("FAIL sb_held: got %h want %h", regs_out, b_sw); end
    dcache_resp = 1'b1;
    #1;
    n_cmp++; if (stall_out !== 1'b0 || dcache_write !== 1'b1) begin n_fail++; $display("FAIL sb_resp: got stall %b wr %b want 0 1", stall_out, dcache_write); end
    step();
    n_cmp++; if (regs_out !== b_sb) begin n_fail++; $display("FAIL sb_regs: got %h want %h", regs_out, b_sb); end
    dcache_resp = 1'b0;
  endtask

  task automatic test_lw_hold();
    b_lw = mk(1'b1, 1'b1, 1'b0, ST_SB, LD_LW, 32'h200, 32'h0, 32'h208);
    regs_in = b_lw;
    #1;
    n_cmp++; if (dcache_read !== 1'b1 || stall_out !== 1'b1) begin n_fail++; $display("FAIL lw_miss: got rd %b stall %b want 1 1", dcache_read, stall_out); end
    step();
    dcache_resp = 1'b1; dcache_rdata = 32'h12345678; stall_in = 1'b1;
    #1;
    n_cmp++; if (dcache_read !== 1'b1 || stall_out !== 1'b0 || dcache_address !== 32'h200) begin n_fail++; $display("FAIL lw_resp: got rd %b stall %b addr %h want 1 0 200", dcache_read, stall_out, dcache_address); end
    step();
    dcache_resp = 1'b0; dcache_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if ({dcache_read, dcache_write, stall_out} !== 3'b000) begin n_fail++; $display("FAIL lw_hold%0d: got %b want 000", i, {dcache_read, dcache_write, stall_out}); end
      step();
      n_cmp++; if (regs_out !== b_sb) begin n_fail++; $display("FAIL lw_held%0d: got %h want %h", i, regs_out, b_sb); end
    end
    stall_in = 1'b0;
    #1;
    n_cmp++; if (dcache_read !== 1'b0) begin n_fail++; $display("FAIL lw_rereq: got %b want 0", dcache_read); end
    step();
    n_cmp++; if (dcache_out !== 32'h12345678) begin n_fail++; $display("FAIL lw_dout: got %h want 12345678", dcache_out); end
    n_cmp++; if (regs_out !== b_lw) begin n_fail++; $display("FAIL lw_regs: got %h want %h", regs_out, b_lw); end
  endtask

  task automatic test_misaligned();
    regs_in = mk(1'b1, 1'b1, 1'b0, ST_SB, LD_LH, 32'h203, 32'h0, 32'h20C);
    #1;
    n_cmp++; if (dcache_read !== 1'b0 || stall_out !== 1'b0) begin n_fail++; $display("FAIL lh_req: got rd %b stall %b want 0 0", dcache_read, stall_out); end
    step();
    n_cmp++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL lh_pulse: got %b want 1", misaligned); end
    n_cmp++; if (regs_out.ctrl.load_regfile !== 1'b0 || regs_out.pc !== 32'h20C) begin n_fail++; $display("FAIL lh_regs: got lr %b pc %h want 0 20c", regs_out.ctrl.load_regfile, regs_out.pc); end
    regs_in = mk(1'b0, 1'b0, 1'b1, ST_SW, LD_LB, 32'h102, 32'h11223344, 32'h210);
    #1;
    n_cmp++; if (dcache_write !== 1'b0 || stall_out !== 1'b0) begin n_fail++; $display("FAIL swmis_req: got wr %b stall %b want 0 0", dcache_write, stall_out); end
    step();
    n_cmp++; if (misaligned !== 1'b1 || regs_out.pc !== 32'h210) begin n_fail++; $display("FAIL swmis_pulse: got %b pc %h want 1 210", misaligned, regs_out.pc); end
    regs_in = mk(1'b0, 1'b0, 1'b0, ST_SB, LD_LB, 32'h0, 32'h0, 32'h214);
    step();
    n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", misaligned); end
  endtask

  task automatic test_reset_mid();
    regs_in = mk(1'b1, 1'b1, 1'b0, ST_SB, LD_LW, 32'h300, 32'h0, 32'h218);
    #1;
    n_cmp++; if (dcache_read !== 1'b1 || stall_out !== 1'b1) begin n_fail++; $display("FAIL rm_miss: got rd %b stall %b want 1 1", dcache_read, stall_out); end
    step();
    n_cmp++; if (regs_out.pc !== 32'h214) begin n_fail++; $display("FAIL rm_held: got %h want 214", regs_out.pc); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (dcache_read !== 1'b0 || stall_out !== 1'b0) begin n_fail++; $display("FAIL rm_drop: got rd %b stall %b want 0 0", dcache_read, stall_out); end
    n_cmp++; if (regs_out !== '0 || dcache_out !== 32'h0) begin n_fail++; $display("FAIL rm_clear: got %h/%h want 0/0", regs_out, dcache_out); end
    rst = 1'b0;
    b_lw2 = mk(1'b1, 1'b1, 1'b0, ST_SB, LD_LW, 32'h304, 32'h0, 32'h480);
    regs_in = b_lw2; dcache_resp = 1'b1; dcache_rdata = 32'hA5A5A5A5;
    #1;
    n_cmp++; if (dcache_read !== 1'b1 || dcache_address !== 32'h304 || stall_out !== 1'b0) begin n_fail++; $display("FAIL rm_next: got rd %b addr %h stall %b want 1 304 0", dcache_read, dcache_address, stall_out); end
    step();
    n_cmp++; if (dcache_out !== 32'hA5A5A5A5 || regs_out !== b_lw2) begin n_fail++; $display("FAIL rm_result: got %h/%h want a5a5a5a5/%h", dcache_out, regs_out, b_lw2); end
    dcache_resp = 1'b0;
  endtask

  task automatic test_stall_nomem();
    logic [5:0]  pat;
    logic [31:0] cur_pc, exp_pc;
    pat    = 6'b011010;
    cur_pc = 32'h500;
    exp_pc = 32'h480;
    regs_in = mk(1'b1, 1'b0, 1'b0, ST_SB, LD_LB, 32'h0000_0042, 32'h0, cur_pc);
    for (int i = 0; i < 6; i++) begin
      stall_in = pat[i];
      #1;
      n_cmp++; if ({dcache_read, dcache_write, stall_out} !== 3'b000) begin n_fail++; $display("FAIL add_req%0d: got %b want 000", i, {dcache_read, dcache_write, stall_out}); end
      step();
      if (!pat[i]) begin
        exp_pc = cur_pc;
        cur_pc = cur_pc + 32'd4;
        regs_in.pc = cur_pc;
      end
      n_cmp++; if (regs_out.pc !== exp_pc) begin n_fail++; $display("FAIL add_pc%0d: got %h want %h", i, regs_out.pc, exp_pc); end
    end
    stall_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; dcache_resp = 1'b0; dcache_rdata = 32'h0; regs_in = '0;
    test_reset();
    test_sw_hit();
    test_sb_miss();
    test_lw_hold();
    test_misaligned();
    test_reset_mid();
    test_stall_nomem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
